// File: rtl/ternary_pkg.sv
// Package: ternary_pkg
// Shared constants for the ternary word sequencer and its op lane.
//   OP_*  : opcode encodings sampled at accept
//   T*    : trit codes, trit = {x1, x0}; T_ILL is the unused {1,1} code
//   seq_state_t : sequencer FSM states
package ternary_pkg;

    localparam logic [1:0] OP_MIN  = 2'b00;
    localparam logic [1:0] OP_MAX  = 2'b01;
    localparam logic [1:0] OP_ANY  = 2'b10;
    localparam logic [1:0] OP_CONS = 2'b11;

    localparam logic [1:0] T0    = 2'b00;
    localparam logic [1:0] T1    = 2'b01;
    localparam logic [1:0] T2    = 2'b10;
    localparam logic [1:0] T_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic is_illegal(input logic [1:0] t);
        return (t == T_ILL);
    endfunction

endpackage

// File: rtl/ternary_op_lane.sv
// Single-trit ternary cells and the op lane that muxes between them.
//   ternary_min/max/any/consensus : a0,a1,b0,b1 -> y0,y1 (one trit each)
//   ternary_op_lane               : a0,a1,b0,b1,op[1:0] -> out0,out1
// All combinational. Cells compare raw 2-bit codes, so an illegal {1,1}
// input simply behaves as the code value 3 -- deterministic, not flagged.

module ternary_min
    import ternary_pkg::*;
(
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic y0,
    output logic y1
);
    logic [1:0] a, b, y;
    assign a = {a1, a0};
    assign b = {b1, b0};
    assign y = (a < b) ? a : b;
    assign {y1, y0} = y;
endmodule

module ternary_max
    import ternary_pkg::*;
(
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic y0,
    output logic y1
);
    logic [1:0] a, b, y;
    assign a = {a1, a0};
    assign b = {b1, b0};
    assign y = (a > b) ? a : b;
    assign {y1, y0} = y;
endmodule

module ternary_any
    import ternary_pkg::*;
(
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic y0,
    output logic y1
);
    logic [2:0] s;
    logic [1:0] y;
    assign s = {1'b0, a1, a0} + {1'b0, b1, b0};
    // clamp(a+b-1, 0, 2) expressed directly on the sum
    assign y = (s <= 3'd1) ? T0 : ((s == 3'd2) ? T1 : T2);
    assign {y1, y0} = y;
endmodule

module ternary_consensus
    import ternary_pkg::*;
(
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic y0,
    output logic y1
);
    logic [1:0] a, b, y;
    assign a = {a1, a0};
    assign b = {b1, b0};
    assign y = ((a == b) && ((a == T0) || (a == T2))) ? a : T1;
    assign {y1, y0} = y;
endmodule

module ternary_op_lane
    import ternary_pkg::*;
(
    input  logic       a0,
    input  logic       a1,
    input  logic       b0,
    input  logic       b1,
    input  logic [1:0] op,
    output logic       out0,
    output logic       out1
);
    logic [1:0] y_min, y_max, y_any, y_cons;

    ternary_min       u_min  (.a0(a0), .a1(a1), .b0(b0), .b1(b1), .y0(y_min[0]),  .y1(y_min[1]));
    ternary_max       u_max  (.a0(a0), .a1(a1), .b0(b0), .b1(b1), .y0(y_max[0]),  .y1(y_max[1]));
    ternary_any       u_any  (.a0(a0), .a1(a1), .b0(b0), .b1(b1), .y0(y_any[0]),  .y1(y_any[1]));
    ternary_consensus u_cons (.a0(a0), .a1(a1), .b0(b0), .b1(b1), .y0(y_cons[0]), .y1(y_cons[1]));

    always_comb begin
        {out1, out0} = y_min;
        case (op)
            OP_MIN:  {out1, out0} = y_min;
            OP_MAX:  {out1, out0} = y_max;
            OP_ANY:  {out1, out0} = y_any;
            default: {out1, out0} = y_cons;
        endcase
    end
endmodule

// File: rtl/ternary_word_seq.sv
// Module: ternary_word_seq
// Bit-serial sequencer: accepts two TRITS-wide ternary operands and an
// opcode, feeds one trit per clock (LSB first) through a single shared
// ternary_op_lane, and returns the result word over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready only in IDLE)
//   op[1:0]               opcode, sampled at accept
//   a0,a1,b0,b1[TRITS]    operands, trit i = {x1[i], x0[i]}
//   out_valid/out_ready   result handshake
//   r0,r1[TRITS]          result word
//   busy                  state != IDLE
//   err (optional)        illegal operand trit seen, valid with out_valid
// Optional feature macro: TERNARY_SEQ_CHECK_EN (adds err and illegal-trit
// masking; when undefined illegal trits flow through the lane untouched).
module ternary_word_seq
    import ternary_pkg::*;
#(
    parameter int TRITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [TRITS-1:0] a0,
    input  logic [TRITS-1:0] a1,
    input  logic [TRITS-1:0] b0,
    input  logic [TRITS-1:0] b1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TRITS-1:0] r0,
    output logic [TRITS-1:0] r1,
    output logic             busy
`ifdef TERNARY_SEQ_CHECK_EN
    ,
    output logic             err
`endif
);
    localparam int CNT_W = $clog2(TRITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TRITS - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       op_reg;
    logic [TRITS-1:0] a0_reg, a1_reg, b0_reg, b1_reg;
    logic [TRITS-1:0] r0_reg, r1_reg;
    logic             lane_y0, lane_y1;
    logic             res_y0, res_y1;
    logic             accept;
    logic             last_trit;

    assign accept    = in_valid & in_ready;
    assign last_trit = (cnt_reg == LAST);

    ternary_op_lane u_lane (
        .a0  (a0_reg[0]),
        .a1  (a1_reg[0]),
        .b0  (b0_reg[0]),
        .b1  (b1_reg[0]),
        .op  (op_reg),
        .out0(lane_y0),
        .out1(lane_y1)
    );

`ifdef TERNARY_SEQ_CHECK_EN
    // Per-trit illegal flags are captured at accept and shifted alongside
    // the operands so each result trit knows whether to be forced to 0.
    logic [TRITS-1:0] ill_mask;
    logic [TRITS-1:0] mask_reg;
    logic             err_reg;

    for (genvar gi = 0; gi < TRITS; gi++) begin : g_ill
        assign ill_mask[gi] = is_illegal({a1[gi], a0[gi]}) | is_illegal({b1[gi], b0[gi]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
            err_reg  <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            if (accept) begin
                mask_reg <= ill_mask;
                err_reg  <= |ill_mask;
            end
        end else if (state_reg == ST_RUN) begin
            mask_reg <= mask_reg >> 1;
        end
    end

    assign res_y0 = lane_y0 & ~mask_reg[0];
    assign res_y1 = lane_y1 & ~mask_reg[0];
    assign err    = err_reg & (state_reg == ST_DONE);
`else
    assign res_y0 = lane_y0;
    assign res_y1 = lane_y1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_trit) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operands shift right, result trits enter at the MSB so
    // that after TRITS shifts trit 0 has landed in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            op_reg  <= OP_MIN;
            a0_reg  <= '0;
            a1_reg  <= '0;
            b0_reg  <= '0;
            b1_reg  <= '0;
            r0_reg  <= '0;
            r1_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a0_reg  <= a0;
                        a1_reg  <= a1;
                        b0_reg  <= b0;
                        b1_reg  <= b1;
                        op_reg  <= op;
                        cnt_reg <= '0;
                    end
                end
                ST_RUN: begin
                    a0_reg  <= a0_reg >> 1;
                    a1_reg  <= a1_reg >> 1;
                    b0_reg  <= b0_reg >> 1;
                    b1_reg  <= b1_reg >> 1;
                    r0_reg  <= {res_y0, r0_reg[TRITS-1:1]};
                    r1_reg  <= {res_y1, r1_reg[TRITS-1:1]};
                    cnt_reg <= last_trit ? '0 : cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign r0 = r0_reg;
    assign r1 = r1_reg;

endmodule

// File: tb/tb_ternary_word_seq.sv
// Testbench for ternary_word_seq with TRITS=4. Words are written as
// decimal-looking numbers whose digits are trits, MSB first (2101 etc).
module tb_ternary_word_seq;
    localparam int TRITS = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op = 2'b00;
    logic [TRITS-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [TRITS-1:0] r0, r1;
    logic             busy;
`ifdef TERNARY_SEQ_CHECK_EN
    logic             err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*TRITS-1:0] exp_q[$];

    always #5 clk = ~clk;

    ternary_word_seq #(.TRITS(TRITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r0       (r0),
        .r1       (r1),
        .busy     (busy)
`ifdef TERNARY_SEQ_CHECK_EN
        ,
        .err      (err)
`endif
    );

    // {x1, x0} packing of a word written as decimal digits, MSB first
    function automatic logic [2*TRITS-1:0] enc(input int w);
        logic [TRITS-1:0] x0, x1;
        int d, v;
        v = w;
        for (int i = 0; i < TRITS; i++) begin
            d = v % 10;
            v = v / 10;
            x0[i] = (d == 1);
            x1[i] = (d == 2);
        end
        return {x1, x0};
    endfunction

    // Reference function on trit values
    function automatic int tfun(input logic [1:0] o, input int a, input int b);
        int s;
        case (o)
            2'b00: return (a < b) ? a : b;
            2'b01: return (a > b) ? a : b;
            2'b10: begin
                s = a + b - 1;
                if (s < 0) s = 0;
                if (s > 2) s = 2;
                return s;
            end
            default: return (a == b && a != 1) ? a : 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one accept cycle; returns #1 after the accept edge.
    task automatic send(input logic [1:0] o, input logic [2*TRITS-1:0] aw,
                        input logic [2*TRITS-1:0] bw, input logic [2*TRITS-1:0] ew);
        check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        {a1, a0} = aw;
        {b1, b0} = bw;
        exp_q.push_back(ew);
        step();
        in_valid = 1'b0;
        $display("send op=%0d a=%h b=%h exp=%h", o, aw, bw, ew);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    // Compare result against scoreboard, then handshake.
    task automatic recv(input string tag);
        logic [2*TRITS-1:0] e;
        wait_valid();
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check(tag, {24'b0, r1, r0}, {24'b0, e});
        $display("recv %s r=%h exp=%h", tag, {r1, r0}, e);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_after_handshake", {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [2*TRITS-1:0] aw, bw, ew;
        int ta, tb_, tr;
        logic [1:0] o;

        // Reset state
        #12;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_r", {24'b0, r1, r0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: MIN with latency and busy checks
        send(2'b00, enc(2101), enc(1202), enc(1101));
        for (int i = 0; i < TRITS - 1; i++) begin
            check("lat_busy", {31'b0, busy}, 32'd1);
            check("lat_no_valid", {31'b0, out_valid}, 32'd0);
            step();
        end
        check("lat_busy_last", {31'b0, busy}, 32'd1);
        step();
        check("lat_valid_at_N+TRITS", {31'b0, out_valid}, 32'd1);
        recv("min_2101_1202");

        // 2: MAX then ANY back-to-back
        send(2'b01, enc(2101), enc(1020), enc(2121));
        recv("max_2101_1020");
        send(2'b10, enc(2210), enc(2100), enc(2200));
        recv("any_2210_2100");

        // 3: CONSENSUS with inputs scrambled during RUN
        send(2'b11, enc(2200), enc(2010), enc(2110));
        in_valid = 1'b1;
        op = 2'b00;
        {a1, a0} = enc(0);
        {b1, b0} = enc(2222);
        step();
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        recv("cons_inputs_changed");

        // 4: backpressure in DONE with ignored in_valid pulses
        send(2'b01, enc(1021), enc(2010), enc(2021));
        wait_valid();
        ew = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            step();
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_r_stable", {24'b0, r1, r0}, {24'b0, ew});
        end
        in_valid = 1'b0;
        recv("max_after_stall");
        step();
        check("no_queued_op", {31'b0, busy}, 32'd0);

        // 5: reset at counter=2 aborts the operation
        send(2'b10, enc(2222), enc(2222), enc(2222));
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(2'b00, enc(0), enc(2222), enc(0));
        recv("min_after_abort");

        // Random legal words against the reference model
        for (int k = 0; k < 8; k++) begin
            o = 2'($urandom_range(0, 3));
            aw = '0; bw = '0; ew = '0;
            for (int i = 0; i < TRITS; i++) begin
                ta  = $urandom_range(0, 2);
                tb_ = $urandom_range(0, 2);
                tr  = tfun(o, ta, tb_);
                aw[i] = (ta == 1); aw[i+TRITS] = (ta == 2);
                bw[i] = (tb_ == 1); bw[i+TRITS] = (tb_ == 2);
                ew[i] = (tr == 1); ew[i+TRITS] = (tr == 2);
            end
            send(o, aw, bw, ew);
            recv("random_op");
        end

`ifdef TERNARY_SEQ_CHECK_EN
        // 6: illegal trit 0 in A forces result trit 0 to 0 and raises err
        aw = enc(1210);
        aw[0] = 1'b1;
        aw[TRITS] = 1'b1;
        send(2'b01, aw, enc(1111), enc(1210));
        wait_valid();
        check("err_set", {31'b0, err}, 32'd1);
        recv("max_illegal_masked");
        check("err_idle", {31'b0, err}, 32'd0);
        send(2'b01, enc(1210), enc(1111), enc(1211));
        wait_valid();
        check("err_clear", {31'b0, err}, 32'd0);
        recv("max_legal");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
